pwm_decoder: RTL and testbench



---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_decoder_if.sv | 17 +
 rtl/pwm_sync_edge.sv | 30 +++
 rtl/pwm_decoder.sv | 135 +++++++++++++
 tb/tb_pwm_decoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the servo PWM generator/decoder pair.
// Generator high times and frame length are kept here so both sides agree.
package pwm_pkg;

    localparam int CNT_W_DEF   = 21;

    localparam int GEN_HIGH_00 = 50_000;
    localparam int GEN_HIGH_01 = 150_000;
    localparam int GEN_HIGH_10 = 240_000;
    localparam int GEN_FRAME   = 1_000_000;

    localparam int TH_01_DEF   = 100_000;
    localparam int TH_10_DEF   = 195_000;
    localparam int TIMEOUT_DEF = 1_100_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_decoder_if.sv
// PWM decoder bus: raw PWM input toward the decoder, measurement results back.
// No handshake; valid is a one-cycle strobe with no backpressure.
interface pwm_decoder_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             pwm_in;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [1:0]       pos;
    logic             valid;
    logic             timeout;

    modport master (output pwm_in, input width, period, pos, valid, timeout);
    modport slave  (input pwm_in, output width, period, pos, valid, timeout);
endinterface

// File: rtl/pwm_sync_edge.sv
// 2-flop synchronizer plus edge detector; rise/fall are usable 2 clk after d_i changes.
// Free-running, no backpressure. Identical latency on both edges.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign s_o    = sync2_q;
    assign rise_o =  sync2_q & ~prev_q;
    assign fall_o = ~sync2_q &  prev_q;
endmodule

// File: rtl/pwm_decoder.sv
// Measures PWM high time and period, classifies high time into a 2-bit position code.
// valid strobes 3 clk after the closing pwm_in rise; no backpressure, results hold until next publish.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TH_01   = TH_01_DEF,
    parameter int TH_10   = TH_10_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_decoder_if.slave bus
);
    logic s;
    logic rise;
    logic fall;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.pwm_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             publish;
    logic             set_timeout;
    logic             at_timeout;

    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] period_q;
    logic [1:0]       pos_q;
    logic             valid_q;
    logic             timeout_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] h);
        if (h >= CNT_W'(TH_10)) return 2'b10;
        if (h >= CNT_W'(TH_01)) return 2'b01;
        return 2'b00;
    endfunction

    assign at_timeout = (pcnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        pcnt_d      = pcnt_q;
        publish     = 1'b0;
        set_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                    pcnt_d  = CNT_W'(1);
                end
            end
            HIGH: begin
                if (at_timeout) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                    if (fall) begin
                        state_d = LOW;
                    end else if (s) begin
                        hcnt_d = sat_inc(hcnt_q);
                    end
                end
            end
            LOW: begin
                // A rise on the timeout cycle still closes the period normally.
                if (rise) begin
                    publish = 1'b1;
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                    pcnt_d  = CNT_W'(1);
                end else if (at_timeout) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q   <= '0;
            period_q  <= '0;
            pos_q     <= 2'b00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                width_q   <= hcnt_q;
                period_q  <= pcnt_q;
                pos_q     <= classify(hcnt_q);
                timeout_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.width   = width_q;
    assign bus.period  = period_q;
    assign bus.pos     = pos_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder with counts scaled down by 1000 (TIMEOUT=1100, frame=1000).
module tb_pwm_decoder;
    localparam int CW   = 12;
    localparam int T01  = 100;
    localparam int T10  = 195;
    localparam int TOUT = 1100;

    logic clk = 1'b0;
    logic rst_n;

    pwm_decoder_if #(.CNT_W(CW)) bus ();

    pwm_decoder #(
        .CNT_W   (CW),
        .TH_01   (T01),
        .TH_10   (T10),
        .TIMEOUT (TOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int l;
        int w;
        int p;
        int pos;
    } vec_t;

    typedef struct {
        int cyc;
        int w;
        int p;
        int pos;
        int to;
    } pub_t;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_rise = 0;
    int   to_cyc = -1;
    logic to_prev = 1'b0;
    pub_t pubq[$];
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.valid)
            pubq.push_back('{cyc, int'(bus.width), int'(bus.period), int'(bus.pos), int'(bus.timeout)});
        if (bus.timeout && !to_prev) to_cyc = cyc;
        to_prev = bus.timeout;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int h, input int l);
        bus.pwm_in = 1'b1;
        last_rise  = cyc;
        repeat (h) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic expect_none(input string name);
        check(name, pubq.size(), 0);
        pubq.delete();
    endtask

    task automatic expect_pub(input string name, input int w, input int p, input int pos, input int rc);
        pub_t e;
        check({name, "_nvalid"}, pubq.size(), 1);
        if (pubq.size() > 0) begin
            e = pubq.pop_front();
            check({name, "_latency"}, e.cyc - rc, 3);
            check({name, "_width"}, e.w, w);
            check({name, "_period"}, e.p, p);
            check({name, "_pos"}, e.pos, pos);
            check({name, "_timeout"}, e.to, 0);
        end
        pubq.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pubq.delete();
        to_cyc = -1;
    endtask

    initial begin
        int rc;
        vecs[0] = '{50,  950, 50,  1000, 0};
        vecs[1] = '{150, 850, 150, 1000, 1};
        vecs[2] = '{240, 760, 240, 1000, 2};
        vecs[3] = '{99,  101, 99,  200,  0};
        vecs[4] = '{100, 100, 100, 200,  1};
        vecs[5] = '{194, 6,   194, 200,  1};
        vecs[6] = '{195, 5,   195, 200,  2};
        vecs[7] = '{1,   4,   1,   5,    0};

        rst_n      = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_width",   int'(bus.width),   0);
        check("rst_period",  int'(bus.period),  0);
        check("rst_pos",     int'(bus.pos),     0);
        check("rst_valid",   int'(bus.valid),   0);
        check("rst_timeout", int'(bus.timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each pulse's rise closes the previous vector's period.
        pulse(vecs[0].h, vecs[0].l);
        expect_none("first_rise");
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) pulse(vecs[i].h, vecs[i].l);
            else       pulse(10, 10);
            expect_pub($sformatf("vec%0d", i - 1), vecs[i-1].w, vecs[i-1].p, vecs[i-1].pos, last_rise);
        end

        // Stuck low after a rise.
        do_reset();
        pulse(5, 1200);
        rc = last_rise;
        check("lo_to_cyc", to_cyc, rc + 3 + TOUT);
        expect_none("lo_no_valid");
        check("lo_to_flag", int'(bus.timeout), 1);
        pulse(10, 20);
        expect_none("lo_restart");
        check("lo_to_sticky", int'(bus.timeout), 1);
        pulse(10, 20);
        expect_pub("lo_pub", 10, 30, 0, last_rise);
        check("lo_to_clr", int'(bus.timeout), 0);

        // Stuck high after a rise.
        do_reset();
        bus.pwm_in = 1'b1;
        rc = cyc;
        repeat (1200) @(negedge clk);
        check("hi_to_cyc", to_cyc, rc + 3 + TOUT);
        expect_none("hi_no_valid");
        check("hi_to_flag", int'(bus.timeout), 1);
        bus.pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        pulse(10, 20);
        expect_none("hi_restart");
        pulse(10, 20);
        expect_pub("hi_pub", 10, 30, 0, last_rise);

        // Reset pulsed mid-HIGH.
        do_reset();
        pulse(50, 50);
        bus.pwm_in = 1'b1;
        rc = cyc;
        repeat (10) @(negedge clk);
        expect_pub("mr_pre", 50, 100, 0, rc);
        rst_n      = 1'b0;
        bus.pwm_in = 1'b0;
        #1;
        check("mr_width",   int'(bus.width),   0);
        check("mr_period",  int'(bus.period),  0);
        check("mr_pos",     int'(bus.pos),     0);
        check("mr_valid",   int'(bus.valid),   0);
        check("mr_timeout", int'(bus.timeout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pubq.delete();
        pulse(30, 30);
        expect_none("mr_first");
        pulse(20, 20);
        expect_pub("mr_pub", 30, 60, 0, last_rise);

        // Rise lands exactly on the timeout cycle.
        do_reset();
        pulse(100, TOUT - 100);
        expect_none("tr_first");
        pulse(10, 10);
        expect_pub("tr_pub", 100, TOUT, 1, last_rise);
        check("tr_to_flag", int'(bus.timeout), 0);
        check("tr_to_cyc", to_cyc, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
